mac_vec_acc: RTL and testbench
==============================

// Module: mac_vec_acc
// PURPOSE
//  Parametrised, pipelined signed multiply-accumulate with saturation and
//  dot-product framing. Accumulates VEC_LEN products, emits result with a 1-cycle
//  valid_out pulse, then auto-restarts. VEC_LEN=0 gives running accumulation.
//  Next-generation drop-in for the Stage_1 MAC datapath.
// PARAMETERS
//  IN_W       10  signed operand width (a, b)
//  ACC_W      20  accumulator/result width; must be >= 2*IN_W
//  MUL_STAGES 1   register stages after operand capture, 0..3
//  VEC_LEN    4   products per result; 0 = running mode (result every product)
//  SAT        1   1 = clamp to ACC_W signed range, 0 = two's-complement wrap
// PORTS
//  clk        in   1      clock, all logic on posedge
//  reset      in   1      synchronous, active-low reset
//  a          in   IN_W   signed operand
//  b          in   IN_W   signed operand
//  valid_in   in   1      a/b valid this cycle; no back-pressure
//  acc_clr    in   1      sync clear: discard partial vector
//  f          out  ACC_W  signed result, held between pulses
//  valid_out  out  1      1-cycle pulse, f/ovf valid
//  ovf        out  1      saturation/wrap occurred in the vector producing f
// BEHAVIOUR
//  - reset==0 at posedge: operand regs, pipe valids, acc, count, f, valid_out
//    and ovf all go to 0. In-flight data and partial vector are discarded.
//  - Edge k with valid_in=1: a,b captured. Product p = a*b (2*IN_W, sign-ext to
//    ACC_W) passes MUL_STAGES regs with a valid bit. Accumulate step at edge
//    k+MUL_STAGES+1. Latency, last valid_in sample to valid_out high:
//    MUL_STAGES+1 edges. Throughput 1 product/cycle. Gaps allowed anywhere.
//  - Accumulate step, when a valid product arrives:
//      sum = (count==0 ? 0 : acc) + p, computed at ACC_W+1 bits.
//      SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//      SAT=0: truncate to ACC_W.
//      Flag = sum out of range. ovf_acc = (count==0 ? flag : ovf_acc|flag).
//  - count runs 0..VEC_LEN-1. Final product (count==VEC_LEN-1): f<=sum,
//    ovf<=ovf_acc|flag, valid_out<=1, count<=0. Otherwise acc<=sum and count++.
//  - VEC_LEN=0: acc never restarts. Every valid product sets f<=sum,
//    valid_out<=1, and a sticky ovf (cleared only by reset or acc_clr).
//  - No valid product that cycle: acc, count, f and ovf hold; valid_out<=0.
//  - acc_clr=1: count<=0, ovf_acc<=0. Pipeline contents are kept, and f/ovf
//    outputs are not touched. A valid product in the same cycle starts the new
//    vector as element 0 (acc=p, count=1).
//  - A valid_in in the acc_clr cycle is not squashed.
//  - Saturation is applied per step, not once at vector end.
// TESTING (IN_W=10, ACC_W=20, MUL_STAGES=1, VEC_LEN=4, SAT=1 unless noted)
//  1. reset 2 cycles, then back-to-back (3,4),(-5,6),(7,-8),(10,10):
//     exactly one valid_out 2 edges after last input, f=26, ovf=0.
//     f=0, valid_out=0 before.
//  2. Same vector with 1-3 idle cycles between elements -> one pulse, f=26;
//     f stays 26 until the next pulse.
//  3. (511,511)x4 -> f=524287, ovf=1. (-512,511)x4 -> f=-524288, ovf=1.
//     Then (1,1)x4 -> f=4, ovf=0.
//  4. (3,4),(3,4), acc_clr with valid (1,1) same cycle, then (1,1)x3 -> f=4,
//     single pulse.
//  5. VEC_LEN=0, SAT=0: (2,3),(4,5) -> pulses f=6 then f=26. Then (511,511)x3
//     on fresh acc -> last f=-265213, ovf=1 (sticky).
//  6. reset low after 2 of (3,4), then (1,1)x4 -> outputs 0 during reset,
//     then f=4, ovf=0.

Source files
------------

// File: rtl/mac_vec_acc.sv
// rtl/mac_vec_acc.sv - pipelined signed MAC with saturation and dot-product framing
module mac_vec_acc #(
    parameter int IN_W       = 10,
    parameter int ACC_W      = 20,
    parameter int MUL_STAGES = 1,
    parameter int VEC_LEN    = 4,
    parameter bit SAT        = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    input  logic                    acc_clr,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out,
    output logic                    ovf
);

    localparam int PW = 2 * IN_W;
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CW-1:0]    LAST    = CW'((VEC_LEN > 0) ? VEC_LEN - 1 : 0);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Operand capture stage
    logic signed [IN_W-1:0] a_q, b_q;
    logic                   in_v_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            in_v_q <= 1'b0;
        end else begin
            in_v_q <= valid_in;
            if (valid_in) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    logic signed [PW-1:0]    mul_w;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] p_acc;
    logic                    v_acc;

    assign mul_w    = a_q * b_q;
    assign prod_ext = ACC_W'(mul_w);

    generate
        if (MUL_STAGES == 0) begin : g_nopipe
            assign p_acc = prod_ext;
            assign v_acc = in_v_q;
        end else begin : g_pipe
            logic signed [ACC_W-1:0] p_q [MUL_STAGES];
            logic [MUL_STAGES-1:0]   v_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < MUL_STAGES; i++) begin
                        p_q[i] <= '0;
                    end
                    v_q <= '0;
                end else begin
                    p_q[0] <= prod_ext;
                    v_q[0] <= in_v_q;
                    for (int i = 1; i < MUL_STAGES; i++) begin
                        p_q[i] <= p_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign p_acc = p_q[MUL_STAGES-1];
            assign v_acc = v_q[MUL_STAGES-1];
        end
    endgenerate

    // Accumulate stage state
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_acc_q, ovf_acc_d;
    logic signed [ACC_W-1:0] f_q, f_d;
    logic                    vout_q, vout_d;
    logic                    ovf_q, ovf_d;

    // acc_clr makes a same-cycle product element 0 of a fresh vector
    logic [CW-1:0]           cnt_eff;
    logic                    fresh;
    logic signed [ACC_W-1:0] base_w;
    logic signed [ACC_W:0]   sum_w;
    logic                    flag_w;
    logic signed [ACC_W-1:0] step_w;
    logic                    ovf_new;

    assign cnt_eff = acc_clr ? '0 : cnt_q;
    assign fresh   = (cnt_eff == '0);
    assign base_w  = fresh ? '0 : acc_q;
    assign sum_w   = {base_w[ACC_W-1], base_w} + {p_acc[ACC_W-1], p_acc};
    assign flag_w  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    assign step_w  = (SAT && flag_w) ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX)
                                     : sum_w[ACC_W-1:0];
    assign ovf_new = (fresh ? 1'b0 : ovf_acc_q) | flag_w;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        f_d       = f_q;
        ovf_d     = ovf_q;
        vout_d    = 1'b0;
        if (acc_clr) begin
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
        end
        if (v_acc) begin
            if (VEC_LEN == 0) begin
                // Running mode: count only marks whether acc holds a live total
                acc_d     = step_w;
                cnt_d     = CW'(1);
                ovf_acc_d = ovf_new;
                f_d       = step_w;
                ovf_d     = ovf_new;
                vout_d    = 1'b1;
            end else if (cnt_eff == LAST) begin
                f_d       = step_w;
                ovf_d     = ovf_new;
                vout_d    = 1'b1;
                cnt_d     = '0;
                ovf_acc_d = 1'b0;
            end else begin
                acc_d     = step_w;
                cnt_d     = cnt_eff + 1'b1;
                ovf_acc_d = ovf_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            f_q       <= '0;
            vout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            f_q       <= f_d;
            vout_q    <= vout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign f         = f_q;
    assign valid_out = vout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_vec_acc.sv
// tb/tb_mac_vec_acc.sv - directed bench for mac_vec_acc (framed and running modes)
module tb_mac_vec_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic signed [9:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic               vin0 = 1'b0, clr0 = 1'b0, vin1 = 1'b0, clr1 = 1'b0;
    logic signed [19:0] f0, f1;
    logic               vout0, vout1, ovf0, ovf1;

    int errors = 0;
    int checks = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    always #5 clk = ~clk;

    mac_vec_acc dut0 (
        .clk(clk), .reset(rst_n), .a(a0), .b(b0), .valid_in(vin0), .acc_clr(clr0),
        .f(f0), .valid_out(vout0), .ovf(ovf0)
    );

    mac_vec_acc #(.VEC_LEN(0), .SAT(1'b0)) dut1 (
        .clk(clk), .reset(rst_n), .a(a1), .b(b1), .valid_in(vin1), .acc_clr(clr1),
        .f(f1), .valid_out(vout1), .ovf(ovf1)
    );

    always @(negedge clk) begin
        if (vout0) pulses0++;
        if (vout1) pulses1++;
    end

    task automatic step0(input logic v, input int x, input int y, input logic c);
        vin0 = v; a0 = 10'(x); b0 = 10'(y); clr0 = c;
        @(posedge clk); #1;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) step0(1'b0, 0, 0, 1'b0);
    endtask

    task automatic step1(input logic v, input int x, input int y, input logic c);
        vin1 = v; a1 = 10'(x); b1 = 10'(y); clr1 = c;
        @(posedge clk); #1;
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) step1(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle0(2);
        checks++; if (f0 !== 20'd0) begin errors++; $display("FAIL reset_f0: got %0d expected 0", f0); end
        checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL reset_vout0: got %b expected 0", vout0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf0: got %b expected 0", ovf0); end
        checks++; if (f1 !== 20'd0 || vout1 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL reset_dut1: got f=%0d v=%b o=%b expected 0 0 0", f1, vout1, ovf1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int p;
        p = pulses0;
        step0(1'b1, 3, 4, 1'b0);
        checks++; if (vout0 !== 1'b0 || f0 !== 20'd0) begin
            errors++; $display("FAIL b2b_before: got v=%b f=%0d expected v=0 f=0", vout0, f0);
        end
        step0(1'b1, -5, 6, 1'b0);
        step0(1'b1, 7, -8, 1'b0);
        step0(1'b1, 10, 10, 1'b0);
        checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL b2b_lat0: got %b expected 0", vout0); end
        idle0(1);
        checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL b2b_lat1: got %b expected 0", vout0); end
        idle0(1);
        checks++; if (vout0 !== 1'b1) begin errors++; $display("FAIL b2b_lat2: got %b expected 1", vout0); end
        checks++; if (int'(f0) !== 26) begin errors++; $display("FAIL b2b_f: got %0d expected 26", f0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", ovf0); end
        idle0(1);
        checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got %b expected 0", vout0); end
        checks++; if (pulses0 - p !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses0 - p); end
    endtask

    task automatic test_gaps();
        int p;
        p = pulses0;
        step0(1'b1, 3, 4, 1'b0);   idle0(1);
        step0(1'b1, -5, 6, 1'b0);  idle0(3);
        step0(1'b1, 7, -8, 1'b0);  idle0(2);
        step0(1'b1, 10, 10, 1'b0); idle0(3);
        checks++; if (pulses0 - p !== 1) begin errors++; $display("FAIL gaps_pulses: got %0d expected 1", pulses0 - p); end
        checks++; if (int'(f0) !== 26) begin errors++; $display("FAIL gaps_f: got %0d expected 26", f0); end
        idle0(4);
        checks++; if (int'(f0) !== 26 || vout0 !== 1'b0) begin
            errors++; $display("FAIL gaps_hold: got f=%0d v=%b expected f=26 v=0", f0, vout0);
        end
    endtask

    task automatic test_saturation();
        int p;
        p = pulses0;
        for (int i = 0; i < 4; i++) step0(1'b1, 511, 511, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== 524287) begin errors++; $display("FAIL sat_pos_f: got %0d expected 524287", f0); end
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf0); end
        for (int i = 0; i < 4; i++) step0(1'b1, -512, 511, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== -524288) begin errors++; $display("FAIL sat_neg_f: got %0d expected -524288", f0); end
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %b expected 1", ovf0); end
        for (int i = 0; i < 4; i++) step0(1'b1, 1, 1, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== 4) begin errors++; $display("FAIL sat_after_f: got %0d expected 4", f0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL sat_after_ovf: got %b expected 0", ovf0); end
        checks++; if (pulses0 - p !== 3) begin errors++; $display("FAIL sat_pulses: got %0d expected 3", pulses0 - p); end
    endtask

    task automatic test_acc_clr();
        int p;
        p = pulses0;
        step0(1'b1, 3, 4, 1'b0);
        step0(1'b1, 3, 4, 1'b0);
        idle0(2);
        step0(1'b1, 1, 1, 1'b1);
        for (int i = 0; i < 3; i++) step0(1'b1, 1, 1, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== 4) begin errors++; $display("FAIL clr_f: got %0d expected 4", f0); end
        checks++; if (pulses0 - p !== 1) begin errors++; $display("FAIL clr_pulses: got %0d expected 1", pulses0 - p); end
        step0(1'b0, 0, 0, 1'b1);
        checks++; if (int'(f0) !== 4 || vout0 !== 1'b0) begin
            errors++; $display("FAIL clr_outputs_kept: got f=%0d v=%b expected f=4 v=0", f0, vout0);
        end
        // Clear lands while (2,2) is at the accumulator: it becomes element 0
        p = pulses0;
        step0(1'b1, 2, 2, 1'b0);
        step0(1'b1, 9, 9, 1'b0);
        step0(1'b1, 1, 1, 1'b1);
        step0(1'b1, 1, 1, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== 87) begin errors++; $display("FAIL clr_inflight_f: got %0d expected 87", f0); end
        checks++; if (pulses0 - p !== 1) begin errors++; $display("FAIL clr_inflight_pulses: got %0d expected 1", pulses0 - p); end
    endtask

    task automatic test_running();
        int p;
        p = pulses1;
        step1(1'b1, 2, 3, 1'b0);
        step1(1'b1, 4, 5, 1'b0);
        idle1(1);
        checks++; if (vout1 !== 1'b1 || int'(f1) !== 6) begin
            errors++; $display("FAIL run_first: got v=%b f=%0d expected v=1 f=6", vout1, f1);
        end
        idle1(1);
        checks++; if (vout1 !== 1'b1 || int'(f1) !== 26) begin
            errors++; $display("FAIL run_second: got v=%b f=%0d expected v=1 f=26", vout1, f1);
        end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL run_ovf0: got %b expected 0", ovf1); end
        idle1(1);
        step1(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step1(1'b1, 511, 511, 1'b0);
        idle1(3);
        checks++; if (int'(f1) !== -265213) begin errors++; $display("FAIL run_wrap_f: got %0d expected -265213", f1); end
        checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL run_wrap_ovf: got %b expected 1", ovf1); end
        checks++; if (pulses1 - p !== 5) begin errors++; $display("FAIL run_pulses: got %0d expected 5", pulses1 - p); end
        step1(1'b1, 1, 1, 1'b0);
        idle1(2);
        checks++; if (int'(f1) !== -265212 || ovf1 !== 1'b1) begin
            errors++; $display("FAIL run_sticky: got f=%0d o=%b expected f=-265212 o=1", f1, ovf1);
        end
        step1(1'b1, 1, 1, 1'b1);
        idle1(2);
        checks++; if (int'(f1) !== 1 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL run_clr_restart: got f=%0d o=%b expected f=1 o=0", f1, ovf1);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        step0(1'b1, 3, 4, 1'b0);
        step0(1'b1, 3, 4, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step0(1'b0, 0, 0, 1'b0);
            checks++; if (f0 !== 20'd0 || vout0 !== 1'b0 || ovf0 !== 1'b0) begin
                errors++; $display("FAIL midreset_outputs: got f=%0d v=%b o=%b expected 0 0 0", f0, vout0, ovf0);
            end
        end
        rst_n = 1'b1;
        p = pulses0;
        for (int i = 0; i < 4; i++) step0(1'b1, 1, 1, 1'b0);
        idle0(3);
        checks++; if (int'(f0) !== 4 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL midreset_f: got f=%0d o=%b expected f=4 o=0", f0, ovf0);
        end
        checks++; if (pulses0 - p !== 1) begin errors++; $display("FAIL midreset_pulses: got %0d expected 1", pulses0 - p); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_saturation();
        test_acc_clr();
        test_running();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
